// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared constants and helpers for the multiplexed seven-segment controller
// Contents:
//   SEG_OFF       all cathodes released (active-low), DP included
//   hex_to_seg    hex nibble -> active-low segments {CG..CA}
//   digit_cycles  clock cycles spent on each digit slot
package ssd_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Integer division: the frame period may come out slightly faster than
    // the nominal refresh rate when the ratio is not exact.
    function automatic int digit_cycles(input int clk_hz, input int refresh_hz, input int digits);
        return clk_hz / (refresh_hz * digits);
    endfunction

endpackage

// File: rtl/ssd_decoder.sv
// rtl/ssd_decoder.sv - combinational hex nibble to active-low seven-segment pattern
// Ports:
//   nibble  in   4  hex value to show
//   dp      in   1  1 = decimal point lit
//   dark    in   1  1 = all digit segments off (DP still follows dp)
//   seg     out  8  active-low cathodes, [6:0]=CG..CA, [7]=DP
module ssd_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       dark,
    output logic [7:0] seg
);

    always_comb begin
        seg[7]   = ~dp;
        seg[6:0] = dark ? 7'h7F : hex_to_seg(nibble);
    end

endmodule

// File: rtl/ssd_mux_n.sv
// rtl/ssd_mux_n.sv - N-digit multiplexed seven-segment controller with shadow load, LZ suppression and PWM
// Ports:
//   clk          in   1              system clock
//   rst_n        in   1              asynchronous active-low reset
//   data_in      in   4*NUM_DIGITS   nibble i drives digit i (digit 0 = rightmost)
//   load         in   1              strobe capturing data_in, blank, dp_in into pending
//   blank        in   NUM_DIGITS     1 = digit dark
//   dp_in        in   NUM_DIGITS     1 = decimal point lit
//   lz_en        in   1              leading-zero suppression enable
//   brightness   in   BRIGHT_BITS    PWM duty level, sampled at frame boundary
//   anode        out  NUM_DIGITS     active-low digit enables
//   segment      out  8              active-low cathodes, [7]=DP
//   frame_start  out  1              pulse in the first cycle digit 0 is driven
module ssd_mux_n
    import ssd_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int REFRESH_RATE  = 200,
    parameter int NUM_DIGITS    = 8,
    parameter int BRIGHT_BITS   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic                      load,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_en,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic [7:0]                segment,
    output logic                      frame_start
);

    localparam int DC = digit_cycles(CLK_FREQUENCY, REFRESH_RATE, NUM_DIGITS);
    localparam int SW = (DC > 1) ? $clog2(DC) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SW-1:0]            slot_q, slot_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [BRIGHT_BITS-1:0]   pwm_q, pwm_d;

    logic [4*NUM_DIGITS-1:0]  pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]    pend_blank_q, pend_blank_d;
    logic [NUM_DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]  act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]    act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]    act_dp_q, act_dp_d;
    logic [BRIGHT_BITS-1:0]   bright_q, bright_d;

    logic [NUM_DIGITS-1:0]    anode_q, anode_d;
    logic [7:0]               segment_q, segment_d;
    logic                     frame_start_q, frame_start_d;

    logic                     slot_wrap;
    logic                     boundary;
    logic [NUM_DIGITS-1:0]    lz_mask;
    logic [3:0]               cur_nib;
    logic                     cur_dp;
    logic                     cur_supp;
    logic                     digit_on;
    logic [7:0]               dec_seg;

    // Scan counters. The boundary is the last cycle of the last digit slot;
    // the active copy happens on that edge so the whole next frame sees one
    // consistent snapshot.
    always_comb begin
        slot_wrap = (slot_q == SW'(DC - 1));
        boundary  = slot_wrap && (idx_q == IW'(NUM_DIGITS - 1));

        slot_d = slot_wrap ? '0 : slot_q + 1'b1;
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;
    end

    // Pending takes every load (last wins); a load on the boundary edge only
    // reaches pending because active copies the pre-edge pending value.
    always_comb begin
        pend_data_d  = load ? data_in : pend_data_q;
        pend_blank_d = load ? blank   : pend_blank_q;
        pend_dp_d    = load ? dp_in   : pend_dp_q;

        act_data_d   = boundary ? pend_data_q  : act_data_q;
        act_blank_d  = boundary ? pend_blank_q : act_blank_q;
        act_dp_d     = boundary ? pend_dp_q    : act_dp_q;
        bright_d     = boundary ? brightness   : bright_q;
    end

    // A digit is suppressed when it and every more-significant nibble are zero.
    always_comb begin
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run        = run & (act_data_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_en & run;
        end
        lz_mask[0] = 1'b0;
    end

    always_comb begin
        cur_nib  = act_data_q[{idx_q, 2'b00} +: 4];
        cur_dp   = act_dp_q[idx_q];
        cur_supp = lz_mask[idx_q];
    end

    ssd_decoder u_decoder (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .dark   (cur_supp),
        .seg    (dec_seg)
    );

    // The anode stays high when nothing on the digit would light (blanked, or
    // suppressed without DP) and during the PWM-off phase; segments are
    // released whenever the anode is.
    always_comb begin
        digit_on      = !act_blank_q[idx_q] && !(cur_supp && !cur_dp) && (pwm_q < bright_q);
        anode_d       = digit_on ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        segment_d     = digit_on ? dec_seg : SEG_OFF;
        frame_start_d = (slot_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q        <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            pend_data_q   <= '0;
            pend_blank_q  <= '0;
            pend_dp_q     <= '0;
            act_data_q    <= '0;
            act_blank_q   <= '0;
            act_dp_q      <= '0;
            bright_q      <= '0;
            anode_q       <= '1;
            segment_q     <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            pend_data_q   <= pend_data_d;
            pend_blank_q  <= pend_blank_d;
            pend_dp_q     <= pend_dp_d;
            act_data_q    <= act_data_d;
            act_blank_q   <= act_blank_d;
            act_dp_q      <= act_dp_d;
            bright_q      <= bright_d;
            anode_q       <= anode_d;
            segment_q     <= segment_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign segment     = segment_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_mux_n.sv
// tb/tb_ssd_mux_n.sv - self-checking bench for ssd_mux_n against a frame-level reference model
module tb_ssd_mux_n;

    localparam int ND   = 4;
    localparam int DC   = 5;
    localparam int FR   = ND * DC;
    localparam int MAXE = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_in = '0;
    logic        load = 1'b0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic [1:0]  brightness = '0;
    logic [3:0]  anode;
    logic [7:0]  segment;
    logic        frame_start;

    int nerr = 0;
    int nchk = 0;
    int ecnt = 0;

    // Input log indexed by clock edge number since reset release.
    logic        load_l  [0:MAXE-1];
    logic [15:0] data_l  [0:MAXE-1];
    logic [3:0]  blank_l [0:MAXE-1];
    logic [3:0]  dp_l    [0:MAXE-1];
    logic [1:0]  bri_l   [0:MAXE-1];
    logic        lz_l    [0:MAXE-1];

    ssd_mux_n #(
        .CLK_FREQUENCY (1000),
        .REFRESH_RATE  (50),
        .NUM_DIGITS    (ND),
        .BRIGHT_BITS   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .load        (load),
        .blank       (blank),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .brightness  (brightness),
        .anode       (anode),
        .segment     (segment),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Expected outputs after edge k: frame m shows the last load made before
    // the boundary edge m*FR-1 and the brightness present on that edge.
    function automatic void model(input int k, output logic [3:0] an, output logic [7:0] sg,
                                  output logic fs);
        int m, idx, pwm;
        logic [15:0] d;
        logic [3:0] bl, dp;
        logic [1:0] br;
        logic supp, lit;
        m = k / FR;
        d = '0; bl = '0; dp = '0; br = '0;
        if (m > 0) begin
            for (int e = m * FR - 2; e >= 0; e--) begin
                if (load_l[e]) begin
                    d = data_l[e]; bl = blank_l[e]; dp = dp_l[e];
                    break;
                end
            end
            br = bri_l[m * FR - 1];
        end
        idx  = (k / DC) % ND;
        pwm  = k % 4;
        supp = lz_l[k] && (idx != 0) && ((d >> (4 * idx)) == 16'h0);
        lit  = !bl[idx] && !(supp && !dp[idx]) && (pwm < int'(br));
        an   = lit ? ~(4'b0001 << idx) : 4'hF;
        sg   = lit ? {~dp[idx], (supp ? 7'h7F : ref_seg(d[4*idx +: 4]))} : 8'hFF;
        fs   = (k % FR) == 0;
    endfunction

    task automatic tick();
        load_l[ecnt]  = load;
        data_l[ecnt]  = data_in;
        blank_l[ecnt] = blank;
        dp_l[ecnt]    = dp_in;
        bri_l[ecnt]   = brightness;
        lz_l[ecnt]    = lz_en;
        @(posedge clk);
        ecnt++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        while ((ecnt % FR) != p) tick();
    endtask

    task automatic clear_log();
        for (int i = 0; i < MAXE; i++) load_l[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nchk += 3;
        if (anode !== 4'hF) begin nerr++; $display("FAIL reset_anode got %b exp 1111", anode); end
        if (segment !== 8'hFF) begin nerr++; $display("FAIL reset_segment got %h exp ff", segment); end
        if (frame_start !== 1'b0) begin nerr++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        clear_log();
        ecnt  = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        logic [3:0] ea; logic [7:0] es; logic ef;
        logic [7:0] tab [4];
        int fs_cnt, low_cnt, s;
        tab[0] = 8'h99; tab[1] = 8'hB0; tab[2] = 8'hA4; tab[3] = 8'hF9;
        fs_cnt = 0; low_cnt = 0;
        brightness = 2'd3; blank = '0; dp_in = '0; lz_en = 1'b0;
        data_in = 16'h1234; load = 1'b1;
        for (int j = 0; j < 3 * FR; j++) begin
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL scan_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL scan_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL scan_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
            if (frame_start === 1'b1) fs_cnt++;
            if (j >= FR && j < 2 * FR && anode !== 4'hF) begin
                low_cnt++;
                s = (j % FR) / DC;
                nchk += 2;
                if (anode !== ~(4'b0001 << s)) begin nerr++; $display("FAIL scan_order j=%0d got %b", j, anode); end
                if (segment !== tab[s]) begin nerr++; $display("FAIL scan_digit j=%0d got %h exp %h", j, segment, tab[s]); end
            end
        end
        nchk += 2;
        if (fs_cnt != 3) begin nerr++; $display("FAIL scan_frame_count got %0d exp 3", fs_cnt); end
        if (low_cnt != 15) begin nerr++; $display("FAIL scan_duty got %0d exp 15", low_cnt); end
    endtask

    task automatic test_tear_free();
        logic [3:0] ea; logic [7:0] es; logic ef;
        logic [7:0] want;
        brightness = 2'd3; blank = '0; dp_in = '0; lz_en = 1'b0;
        wait_phase(0);
        for (int j = 0; j < 4 * FR; j++) begin
            if (j == 0)  begin data_in = 16'hAAAA; load = 1'b1; end
            if (j == 27) begin data_in = 16'h5555; load = 1'b1; end
            if (j == 47) begin data_in = 16'h5555; load = 1'b1; end
            if (j == 48) begin data_in = 16'h0F0F; load = 1'b1; end
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL tear_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL tear_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL tear_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
            if (j >= FR && anode !== 4'hF) begin
                if (j < 2 * FR)      want = 8'h88;
                else if (j < 3 * FR) want = 8'h92;
                else                 want = (((j % FR) / DC) % 2 == 0) ? 8'h8E : 8'hC0;
                nchk++;
                if (segment !== want) begin nerr++; $display("FAIL tear_frame j=%0d got %h exp %h", j, segment, want); end
            end
        end
    endtask

    task automatic test_lz();
        logic [3:0] ea; logic [7:0] es; logic ef;
        brightness = 2'd3; blank = '0; lz_en = 1'b1;
        wait_phase(0);
        for (int j = 0; j < 4 * FR; j++) begin
            if (j == 0)      begin data_in = 16'h0040; dp_in = 4'b1000; load = 1'b1; end
            if (j == 2 * FR) begin data_in = 16'h0000; dp_in = 4'b0000; load = 1'b1; end
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL lz_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL lz_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL lz_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
            if (j >= FR && j < 2 * FR && anode === 4'b0111) begin
                nchk++;
                if (segment !== 8'h7F) begin nerr++; $display("FAIL lz_dp_only j=%0d got %h exp 7f", j, segment); end
            end
            if (j >= 3 * FR) begin
                nchk++;
                if (anode !== 4'hF && anode !== 4'hE) begin nerr++; $display("FAIL lz_zero_anode j=%0d got %b", j, anode); end
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_blank_bright();
        logic [3:0] ea; logic [7:0] es; logic ef;
        int lows1, lows0;
        lows1 = 0; lows0 = 0;
        lz_en = 1'b0; dp_in = '0; blank = 4'b0101;
        wait_phase(0);
        for (int j = 0; j < 4 * FR; j++) begin
            if (j == 0)      begin data_in = 16'($urandom); brightness = 2'd1; load = 1'b1; end
            if (j == 2 * FR) brightness = 2'd0;
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL bb_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL bb_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL bb_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
            if (j >= FR && j < 2 * FR && anode !== 4'hF) lows1++;
            if (j >= 3 * FR && anode !== 4'hF) lows0++;
        end
        nchk += 2;
        if (lows1 != 2) begin nerr++; $display("FAIL bb_duty1 got %0d exp 2", lows1); end
        if (lows0 != 0) begin nerr++; $display("FAIL bb_duty0 got %0d exp 0", lows0); end
        blank = '0;
    endtask

    task automatic test_random();
        logic [3:0] ea; logic [7:0] es; logic ef;
        for (int j = 0; j < 240; j++) begin
            load       = ($urandom_range(0, 3) == 0);
            data_in    = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data_in = data_in & 16'h00FF;
            blank      = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            dp_in      = 4'($urandom);
            lz_en      = 1'($urandom);
            brightness = 2'($urandom);
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL rand_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL rand_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL rand_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] ea; logic [7:0] es; logic ef;
        int lit;
        lit = 0;
        blank = '0; dp_in = '0; lz_en = 1'b0; brightness = 2'd3;
        data_in = 16'h8888; load = 1'b1;
        tick();
        wait_phase(0);
        tick();
        wait_phase(0);
        while (((ecnt % FR) != 13) || (anode === 4'hF)) begin
            if ((ecnt % FR) == 12) begin data_in = 16'h1234; load = 1'b1; end
            tick();
            if (ecnt > MAXE - 8) break;
        end
        nchk++;
        if (anode === 4'hF) begin nerr++; $display("FAIL rstmid_precondition got %b exp lit digit", anode); end
        #2 rst_n = 1'b0;
        #1;
        nchk += 3;
        if (anode !== 4'hF) begin nerr++; $display("FAIL rstmid_anode got %b exp 1111", anode); end
        if (segment !== 8'hFF) begin nerr++; $display("FAIL rstmid_segment got %h exp ff", segment); end
        if (frame_start !== 1'b0) begin nerr++; $display("FAIL rstmid_frame_start got %b exp 0", frame_start); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_log();
        ecnt = 0;
        load = 1'b0;
        brightness = 2'd0;
        rst_n = 1'b1;
        tick();
        nchk += 2;
        if (frame_start !== 1'b1) begin nerr++; $display("FAIL rstmid_restart_fs got %b exp 1", frame_start); end
        if (anode !== 4'hF) begin nerr++; $display("FAIL rstmid_restart_dark got %b exp 1111", anode); end
        brightness = 2'd3;
        for (int j = 1; j < 3 * FR; j++) begin
            tick();
            model(ecnt - 1, ea, es, ef);
            nchk += 3;
            if (anode !== ea) begin nerr++; $display("FAIL rstmid_anode k=%0d got %b exp %b", ecnt-1, anode, ea); end
            if (segment !== es) begin nerr++; $display("FAIL rstmid_segment k=%0d got %h exp %h", ecnt-1, segment, es); end
            if (frame_start !== ef) begin nerr++; $display("FAIL rstmid_frame_start k=%0d got %b exp %b", ecnt-1, frame_start, ef); end
            if (anode !== 4'hF) begin
                lit++;
                nchk++;
                if (segment !== 8'hC0) begin nerr++; $display("FAIL rstmid_discard k=%0d got %h exp c0", ecnt-1, segment); end
            end
        end
        nchk++;
        if (lit == 0) begin nerr++; $display("FAIL rstmid_lit got %0d exp nonzero", lit); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_lz();
        test_blank_bright();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
